// File: rtl/banked_ram.sv
// Multi-bank single-port synchronous RAM with registered read, error strobe
// and a zero-fill sequencer (all banks after reset, one bank on request).
module banked_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int BANKS  = 2,
  parameter int BANK_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy,
  input  logic              clr,
  input  logic [BANK_W-1:0] clr_bank,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [BANK_W-1:0]   clr_bank_q, clr_bank_n;
  logic                err_n;
  logic                wr_en, rd_en, wipe_all, wipe_one;
  logic                sel_ok, clr_ok;
  logic [DATA_W-1:0]   mem [BANKS][DEPTH];

  // Bank count need not be a power of two, so range-check both selects.
  assign sel_ok = 32'(bank_sel) < 32'(BANKS);
  assign clr_ok = 32'(clr_bank) < 32'(BANKS);
  assign busy   = (state != IDLE);

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    clr_bank_n = clr_bank_q;
    err_n      = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    wipe_all   = 1'b0;
    wipe_one   = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          if (clr_ok) begin
            state_n    = CLR_ONE;
            ptr_n      = '0;
            clr_bank_n = clr_bank;
            err_n      = we | re;
          end else begin
            err_n = 1'b1;
          end
        end else if (we || re) begin
          if (!sel_ok)  err_n = 1'b1;
          else if (we)  wr_en = 1'b1;
          else          rd_en = 1'b1;
        end
      end
      CLR_ALL, CLR_ONE: begin
        err_n    = we | re | clr;
        wipe_all = (state == CLR_ALL);
        wipe_one = (state == CLR_ONE);
        ptr_n    = ptr + 1'b1;
        if (ptr == '1) state_n = IDLE;
      end
      default: state_n = CLR_ALL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLR_ALL;
      ptr        <= '0;
      clr_bank_q <= '0;
      err        <= 1'b0;
      rd_valid   <= 1'b0;
      dout       <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      clr_bank_q <= clr_bank_n;
      err        <= err_n;
      rd_valid   <= rd_en;
      if (rd_en) dout <= mem[bank_sel][addr];
    end
  end

  // Storage has no reset; rst only blocks writes while the sequencer restarts.
  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    always_ff @(posedge clk) begin
      if (!rst) begin
        if (wipe_all || (wipe_one && clr_bank_q == BANK_W'(g)))
          mem[g][ptr] <= '0;
        else if (wr_en && bank_sel == BANK_W'(g))
          mem[g][addr] <= din;
      end
    end
  end

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram: reads push expected data, a monitor pops
// on rd_valid; err pulses and busy cycles are tallied by the monitor.
module tb_banked_ram;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int BANKS  = 3;
  localparam int BANK_W = 2;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [BANK_W-1:0] bank_sel = '0, clr_bank = '0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              rd_valid, busy, err;

  banked_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .BANK_W(BANK_W)) dut (
    .clk(clk), .rst(rst), .bank_sel(bank_sel), .we(we), .re(re), .addr(addr),
    .din(din), .dout(dout), .rd_valid(rd_valid), .busy(busy), .clr(clr),
    .clr_bank(clr_bank), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int err_seen = 0, busy_seen = 0, run = 0, max_run = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("unexpected rd_valid", 32'(rd_valid), 0);
        else check("read data", 32'(dout), 32'(exp_q.pop_front()));
      end
      run = rd_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (err)  err_seen++;
      if (busy) busy_seen++;
    end
  end

  task automatic wr(input int b, input int a, input int d);
    bank_sel = BANK_W'(b); addr = ADDR_W'(a); din = DATA_W'(d); we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input int b, input int a, input int expv);
    bank_sel = BANK_W'(b); addr = ADDR_W'(a); re = 1'b1;
    exp_q.push_back(DATA_W'(expv));
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic rd_rejected(input int b, input int a);
    bank_sel = BANK_W'(b); addr = ADDR_W'(a); re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic fill(input int v);
    for (int b = 0; b < BANKS; b++)
      for (int a = 0; a < DEPTH; a++) wr(b, a, v);
  endtask

  task automatic rd_all(input int v0, input int v1, input int v2);
    for (int a = 0; a < DEPTH; a++) rd(0, a, v0);
    for (int a = 0; a < DEPTH; a++) rd(1, a, v1);
    for (int a = 0; a < DEPTH; a++) rd(2, a, v2);
    settle();
    check("scoreboard drained", exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int start, input int want);
    int n = 0;
    while (busy && n < 200) begin
      settle();
      n++;
    end
    check({name, " ends"}, 32'(busy), 0);
    check({name, " cycles"}, busy_seen - start, want);
  endtask

  task automatic pulse_clr(input int b);
    clr_bank = BANK_W'(b); clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  int b0, e0;

  initial begin : stim
    // Reset and power-on clear
    repeat (3) @(posedge clk);
    #1;
    check("reset dout", 32'(dout), 0);
    check("reset rd_valid", 32'(rd_valid), 0);
    check("reset err", 32'(err), 0);
    check("reset busy", 32'(busy), 1);
    rst = 1'b0;
    b0 = busy_seen;
    wait_idle("power-on clear", b0, DEPTH);
    rd_all(0, 0, 0);

    // Per-bank write/read, back-to-back reads
    wr(0, 3, 8'hA5);
    wr(2, 3, 8'h5A);
    wr(1, 15, 8'hFF);
    max_run = 0;
    rd(0, 3, 8'hA5);
    rd(2, 3, 8'h5A);
    rd(1, 3, 8'h00);
    rd(1, 15, 8'hFF);
    settle();
    check("back-to-back rd_valid run", max_run, 4);

    // Invalid bank
    e0 = err_seen;
    wr(3, 0, 8'h77);
    settle();
    check("err on bad-bank write", err_seen - e0, 1);
    rd_rejected(3, 3);
    settle();
    check("err on bad-bank read", err_seen - e0, 2);
    check("dout held after bad read", 32'(dout), 8'hFF);
    pulse_clr(3);
    settle();
    check("err on bad clr_bank", err_seen - e0, 3);
    check("busy after bad clr", 32'(busy), 0);

    // Single-bank clear
    fill(8'h11);
    rd(2, 0, 8'h11);
    settle();
    pulse_clr(1);
    b0 = busy_seen;
    check("busy on clr entry", 32'(busy), 1);
    e0 = err_seen;
    rd_rejected(0, 4);
    settle();
    check("err on read while busy", err_seen - e0, 1);
    check("dout held while busy", 32'(dout), 8'h11);
    wait_idle("bank1 clear", b0, DEPTH);
    rd_all(8'h11, 0, 8'h11);

    // clr and we collide in IDLE
    e0 = err_seen;
    bank_sel = 0; addr = 5; din = 8'h33; we = 1'b1;
    clr_bank = 0; clr = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; clr = 1'b0;
    b0 = busy_seen;
    check("busy on collision", 32'(busy), 1);
    settle();
    check("err on collision", err_seen - e0, 1);
    wait_idle("collision clear", b0, DEPTH);
    rd(0, 5, 8'h00);
    rd(2, 5, 8'h11);
    settle();

    // Reset on the 8th cycle of a single-bank clear
    fill(8'h22);
    rd(1, 7, 8'h22);
    settle();
    pulse_clr(0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid-clear reset dout", 32'(dout), 0);
    check("mid-clear reset rd_valid", 32'(rd_valid), 0);
    check("mid-clear reset err", 32'(err), 0);
    rst = 1'b0;
    b0 = busy_seen;
    wait_idle("restarted clear", b0, DEPTH);
    rd_all(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/banked_ram.md
Name: banked_ram

Overview:
- Parametrised multi-bank, single-port synchronous RAM; next generation of the team's two-bank lab memory.
- Adds configurable bank count and width, a registered read with a valid strobe, and an error strobe.
- Adds a hardware clear sequencer: zero-fills all banks after reset and one bank on request.
- Sits between the lab datapath/controller and board I/O (switches select bank/address, LEDs show dout).

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words per bank.
- BANKS, 2, number of banks, 1..2**BANK_W; need not be a power of two.
- BANK_W, 1, width of the bank-select fields.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- bank_sel  in  BANK_W  bank addressed by we/re.
- we  in  1  write enable.
- re  in  1  read enable.
- addr  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- dout  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: dout updated by a read.
- busy  out  1  clear sequencer active; accesses rejected.
- clr  in  1  request zero-fill of one bank.
- clr_bank  in  BANK_W  bank to clear.
- err  out  1  one-cycle pulse: rejected request.

Behaviour:
- Reset (rst=1 at an edge):
  - dout=0, rd_valid=0, err=0, busy=1.
  - State CLR_ALL, clear pointer ptr=0.
  - Memory is not written while rst is held.
- FSM states: IDLE, CLR_ALL, CLR_ONE.
- CLR_ALL:
  - Each edge with rst=0 writes 0 to mem[b][ptr] for every b<BANKS, then ptr++.
  - The edge writing ptr=DEPTH-1 sets state=IDLE and busy=0.
  - busy is high for exactly DEPTH cycles after rst falls.
- CLR_ONE:
  - Same as CLR_ALL, but writes only bank clr_bank, latched on entry.
  - Lasts DEPTH cycles; other banks are untouched.
- IDLE, priority clr > we > re:
  - clr=1 and clr_bank<BANKS: enter CLR_ONE, ptr=0, busy=1 at the same edge.
  - If we or re is also high that cycle: the access is dropped and err pulses.
  - clr=1 and clr_bank>=BANKS: no state change; err=1 for one cycle.
  - we=1, bank_sel<BANKS: mem[bank_sel][addr] <= din. No read occurs even if re=1. dout holds, rd_valid=0.
  - re=1, we=0, bank_sel<BANKS: dout <= mem[bank_sel][addr] at that edge. rd_valid=1 for the following cycle. Read latency is 1 cycle.
  - Back-to-back reads produce a valid result every cycle.
  - A read of an address written on the previous edge returns the new data. A same-edge read and write cannot occur (we has priority).
  - we or re with bank_sel>=BANKS: memory and dout unchanged; err=1 for one cycle.
- While busy=1:
  - we, re and clr are ignored.
  - Each cycle with any of them high gives err=1.
  - dout holds its last value; rd_valid=0.
- dout is never cleared by a clear sequence; it changes only on a read or on reset.
- rst asserted mid-clear: aborts immediately and restarts as CLR_ALL from ptr=0 after release. Partially cleared banks end fully zero.
- ptr width is ADDR_W. Wrap from DEPTH-1 does not occur because the state exits first.
- err and rd_valid are registered pulses, one cycle wide, reset to 0.

Test Plan (DATA_W=8, ADDR_W=4, BANKS=3, BANK_W=2):
- Reset cycles:
  - rst high for 3 cycles, then low.
  - Required: busy=1 for 16 cycles after release, then 0.
  - Reading every address of banks 0..2 returns 0x00 with rd_valid one cycle after each re.
- Write/read per bank:
  - Write 0xA5 to bank0/addr3, 0x5A to bank2/addr3, 0xFF to bank1/addr15.
  - Required: reads return the same values one cycle later.
  - Bank1/addr3 still reads 0x00.
  - Back-to-back reads give rd_valid high on consecutive cycles.
- Invalid bank:
  - we with bank_sel=3, din=0x77, then re with bank_sel=3.
  - Required: err pulses once per request; dout unchanged; rd_valid=0.
  - clr with clr_bank=3 gives err and busy stays 0.
- Single-bank clear:
  - Fill all banks with 0x11, pulse clr with clr_bank=1.
  - Required: busy=1 for exactly 16 cycles.
  - A re during busy gives err=1 and dout holds.
  - Afterwards bank1 reads 0x00 everywhere; banks 0 and 2 read 0x11.
- Collision:
  - clr=1 and we=1 in the same IDLE cycle, with addr 5 and din 0x33 in bank 0, clr_bank=0.
  - Required: err=1, CLR_ONE entered, and bank0/addr5 reads 0x00 after the clear.
- Reset mid-clear:
  - Assert rst on the 8th cycle of CLR_ONE.
  - Required: after release, busy is high for 16 cycles and all banks read 0x00.
  - dout=0 and rd_valid=0 immediately after the reset edge.
